// File: rtl/note_tone_gen_pkg.sv
// Shared constants for the note tone generator: widths, rest code,
// FSM encoding and the half-period table for a 50 MHz clock.
package note_tone_gen_pkg;

    localparam int NOTE_W = 6;
    localparam int HALF_W = 18;
    localparam int NOTES  = 1 << NOTE_W;

    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // half(n) = round(25e6 / (110 * 2^((n-1)/12))) clock cycles; entry 0 is the rest slot
    localparam logic [HALF_W-1:0] HALF_TABLE [NOTES] = '{
        18'd0,
        18'd227273, 18'd214517, 18'd202477, 18'd191113, 18'd180386, 18'd170262,
        18'd160706, 18'd151686, 18'd143173, 18'd135137, 18'd127553, 18'd120394,
        18'd113636, 18'd107258, 18'd101238, 18'd95556,  18'd90193,  18'd85131,
        18'd80353,  18'd75843,  18'd71586,  18'd67569,  18'd63776,  18'd60197,
        18'd56818,  18'd53629,  18'd50619,  18'd47778,  18'd45097,  18'd42566,
        18'd40177,  18'd37922,  18'd35793,  18'd33784,  18'd31888,  18'd30098,
        18'd28409,  18'd26815,  18'd25310,  18'd23889,  18'd22548,  18'd21283,
        18'd20088,  18'd18961,  18'd17897,  18'd16892,  18'd15944,  18'd15049,
        18'd14205,  18'd13407,  18'd12655,  18'd11945,  18'd11274,  18'd10641,
        18'd10044,  18'd9480,   18'd8948,   18'd8446,   18'd7972,   18'd7525,
        18'd7102,   18'd6704,   18'd6327
    };

endpackage

// File: rtl/note_period_rom.sv
// 64-entry synchronous half-period ROM: note index in, half-period in
// clock cycles out one cycle later. Octave shifting is done by the caller.
module note_period_rom
    import note_tone_gen_pkg::*;
(
    input  logic              clk50mhz,
    input  logic              rst,
    input  logic [NOTE_W-1:0] note,
    output logic [HALF_W-1:0] half
);

    logic [HALF_W-1:0] rom_mem [NOTES];
    logic [HALF_W-1:0] half_reg;

    generate
        for (genvar gi = 0; gi < NOTES; gi++) begin : g_rom
            assign rom_mem[gi] = HALF_TABLE[gi];
        end
    endgenerate

    // registered read so the table maps onto block RAM / LUT ROM
    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            half_reg <= '0;
        end else begin
            half_reg <= rom_mem[note];
        end
    end

    assign half = half_reg;

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator fed by the portamento stage. Two pipeline
// stages (input capture, ROM lookup) feed a two-state FSM whose period
// and note only change on a toggle boundary, keeping glides glitch-free
// and guaranteeing the waveform always ends low.
module note_tone_gen
    import note_tone_gen_pkg::*;
(
    input  logic              clk50mhz,
    input  logic              rst,
    input  logic [NOTE_W-1:0] note_in,
    input  logic              en,
    input  logic [1:0]        octave,
    output logic              tone_out,
    output logic              busy,
    output logic [NOTE_W-1:0] note_playing
);

    // stage 1: captured inputs
    logic [NOTE_W-1:0] note_q_reg;
    logic              en_q_reg;
    logic [1:0]        oct_q_reg;

    // stage 2: side-band aligned with the ROM output
    logic [NOTE_W-1:0] note_s2_reg;
    logic              en_s2_reg;
    logic [1:0]        oct_s2_reg;
    logic [HALF_W-1:0] rom_half;

    logic [HALF_W-1:0] half_next;
    logic              play_next;
    logic [NOTE_W-1:0] note_next;

    // FSM / waveform state
    logic [0:0]        state_reg, state_nxt;
    logic [HALF_W-1:0] cnt_reg, cnt_next;
    logic [HALF_W-1:0] half_cur_reg, half_cur_next;
    logic              tone_reg, tone_next;
    logic [NOTE_W-1:0] note_play_reg, note_play_next;
    logic              boundary;

    // stage 1: register raw inputs every cycle
    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            note_q_reg <= '0;
            en_q_reg   <= 1'b0;
            oct_q_reg  <= '0;
        end else begin
            note_q_reg <= note_in;
            en_q_reg   <= en;
            oct_q_reg  <= octave;
        end
    end

    note_period_rom u_rom (
        .clk50mhz (clk50mhz),
        .rst      (rst),
        .note     (note_q_reg),
        .half     (rom_half)
    );

    // stage 2: delay note/en/octave by one cycle to line up with the ROM read
    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            note_s2_reg <= '0;
            en_s2_reg   <= 1'b0;
            oct_s2_reg  <= '0;
        end else begin
            note_s2_reg <= note_q_reg;
            en_s2_reg   <= en_q_reg;
            oct_s2_reg  <= oct_q_reg;
        end
    end

    assign half_next = rom_half >> oct_s2_reg;
    assign play_next = en_s2_reg && (note_s2_reg != NOTE_REST);
    assign note_next = note_s2_reg;

    // half_cur is never below 790 in RUN, so the subtraction cannot wrap there
    assign boundary = (cnt_reg == (half_cur_reg - HALF_W'(1)));

    // next-state logic: start from IDLE, toggle or stop only on a boundary
    always_comb begin
        state_nxt      = state_reg;
        cnt_next       = cnt_reg;
        half_cur_next  = half_cur_reg;
        tone_next      = tone_reg;
        note_play_next = note_play_reg;
        if (state_reg == ST_IDLE) begin
            cnt_next       = '0;
            half_cur_next  = '0;
            tone_next      = 1'b0;
            note_play_next = NOTE_REST;
            if (play_next) begin
                half_cur_next  = half_next;
                note_play_next = note_next;
                tone_next      = 1'b1;
                state_nxt      = ST_RUN;
            end
        end else begin
            if (boundary) begin
                cnt_next = '0;
                if (play_next) begin
                    tone_next      = ~tone_reg;
                    half_cur_next  = half_next;
                    note_play_next = note_next;
                end else begin
                    tone_next      = 1'b0;
                    half_cur_next  = '0;
                    note_play_next = NOTE_REST;
                    state_nxt      = ST_IDLE;
                end
            end else begin
                cnt_next = cnt_reg + HALF_W'(1);
            end
        end
    end

    // waveform state registers
    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            half_cur_reg  <= '0;
            tone_reg      <= 1'b0;
            note_play_reg <= NOTE_REST;
        end else begin
            state_reg     <= state_nxt;
            cnt_reg       <= cnt_next;
            half_cur_reg  <= half_cur_next;
            tone_reg      <= tone_next;
            note_play_reg <= note_play_next;
        end
    end

    assign tone_out     = tone_reg;
    assign busy         = (state_reg == ST_RUN);
    assign note_playing = note_play_reg;

endmodule

// File: tb/tb_note_tone_gen.sv
// Directed bench for note_tone_gen. Stimulus pushes the expected RUN
// levels (value, length, note) into a queue; a monitor measures every
// completed level and compares it against the queue head.
module tb_note_tone_gen;

    logic       clk50mhz = 1'b0;
    logic       rst;
    logic [5:0] note_in;
    logic       en;
    logic [1:0] octave;
    logic       tone_out;
    logic       busy;
    logic [5:0] note_playing;

    always #10 clk50mhz = ~clk50mhz;

    note_tone_gen dut (
        .clk50mhz     (clk50mhz),
        .rst          (rst),
        .note_in      (note_in),
        .en           (en),
        .octave       (octave),
        .tone_out     (tone_out),
        .busy         (busy),
        .note_playing (note_playing)
    );

    typedef struct {
        logic lvl;
        int   len;
        int   np;
    } level_t;

    level_t exp_q[$];
    int     total = 0;
    int     bad   = 0;
    logic   mon_skip = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic expect_level(input logic lvl, input int len, input int np);
        level_t e;
        e.lvl = lvl;
        e.len = len;
        e.np  = np;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk50mhz);
        #1;
    endtask

    task automatic wait_tone(input string name, input logic v, input int budget);
        int i;
        i = 0;
        while (tone_out !== v && i < budget) begin
            tick(1);
            i++;
        end
        total++;
        if (tone_out !== v) begin
            bad++;
            $display("FAIL %s: tone_out=%0b after %0d cycles, want %0b", name, tone_out, budget, v);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        i = 0;
        while (busy !== 1'b0 && i < budget) begin
            tick(1);
            i++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s: busy=%0b after %0d cycles, want 0", name, busy, budget);
        end
    endtask

    // monitor: measures each RUN level and checks it against the queue head
    initial begin
        logic   pt, pb;
        int     run_len, cur_np;
        level_t e;
        pt = 1'b0;
        pb = 1'b0;
        run_len = 0;
        cur_np = 0;
        forever begin
            @(negedge clk50mhz);
            if (pb === 1'b1 && (tone_out !== pt || busy !== 1'b1)) begin
                if (!mon_skip) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL level: unexpected level=%0b len=%0d note=%0d", pt, run_len, cur_np);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.lvl !== pt || e.len != run_len || e.np != cur_np) begin
                            bad++;
                            $display("FAIL level: got lvl=%0b len=%0d note=%0d want lvl=%0b len=%0d note=%0d",
                                     pt, run_len, cur_np, e.lvl, e.len, e.np);
                        end else begin
                            $display("ok   level: lvl=%0b len=%0d note=%0d", pt, run_len, cur_np);
                        end
                    end
                end
            end
            if (tone_out !== pt || (busy === 1'b1 && pb !== 1'b1)) begin
                run_len = 1;
                cur_np  = int'(note_playing);
            end else begin
                run_len++;
            end
            pt = tone_out;
            pb = busy;
        end
    end

    // stimulus
    initial begin
        rst = 1'b1; note_in = 6'd0; en = 1'b0; octave = 2'd0;
        tick(3);
        check("reset tone_out", tone_out, 0);
        check("reset busy", busy, 0);
        check("reset note_playing", note_playing, 0);
        rst = 1'b0;
        tick(3);
        check("idle tone_out", tone_out, 0);

        // start note 25, octave 3: 56818>>3 = 7102
        note_in = 6'd25; octave = 2'd3; en = 1'b1;
        expect_level(1'b1, 7102, 25);
        tick(1);
        tick(1);
        check("latency edge k+1 tone_out", tone_out, 0);
        tick(1);
        check("latency edge k+2 tone_out", tone_out, 1);
        check("start busy", busy, 1);
        check("start note_playing", note_playing, 25);

        // glide to note 37 mid-high: 28409>>3 = 3551 from next level
        tick(100);
        note_in = 6'd37;
        expect_level(1'b0, 3551, 37);
        expect_level(1'b1, 3551, 37);
        wait_tone("glide low", 1'b0, 10000);
        wait_tone("glide high", 1'b1, 10000);

        // note 63, octave 3: 6327>>3 = 790
        tick(100);
        note_in = 6'd63;
        expect_level(1'b0, 790, 63);
        expect_level(1'b1, 790, 63);
        expect_level(1'b0, 790, 63);
        wait_tone("n63 low", 1'b0, 10000);
        wait_tone("n63 high", 1'b1, 2000);
        wait_tone("n63 low2", 1'b0, 2000);

        // octave 1: 6327>>1 = 3163
        tick(100);
        octave = 2'd1;
        expect_level(1'b1, 3163, 63);
        expect_level(1'b0, 3163, 63);
        wait_tone("oct1 high", 1'b1, 2000);
        wait_tone("oct1 low", 1'b0, 5000);

        // en glitch within the low level must not disturb the waveform
        tick(100);
        en = 1'b0;
        tick(50);
        en = 1'b1;
        expect_level(1'b1, 3163, 63);
        wait_tone("glitch high", 1'b1, 5000);

        // rest during high level: high completes, then idle low
        tick(100);
        note_in = 6'd0;
        wait_tone("stop high", 1'b0, 5000);
        check("stop-high busy", busy, 0);
        check("stop-high note_playing", note_playing, 0);
        tick(20);
        check("after stop tone_out", tone_out, 0);
        check("after stop busy", busy, 0);

        // rest during low level: low completes, idle without extra pulse
        note_in = 6'd37; octave = 2'd3;
        expect_level(1'b1, 3551, 37);
        expect_level(1'b0, 3551, 37);
        wait_tone("restart high", 1'b1, 10);
        wait_tone("restart low", 1'b0, 5000);
        tick(100);
        note_in = 6'd0;
        wait_idle("stop low", 5000);
        check("stop-low tone_out", tone_out, 0);
        check("stop-low note_playing", note_playing, 0);
        tick(20);

        // reset 1000 cycles into a high level, with inputs active during reset
        note_in = 6'd37;
        wait_tone("pre-reset high", 1'b1, 10);
        tick(1000);
        mon_skip = 1'b1;
        rst = 1'b1;
        note_in = 6'd1;
        tick(1);
        check("mid-run reset tone_out", tone_out, 0);
        check("mid-run reset busy", busy, 0);
        check("mid-run reset note_playing", note_playing, 0);
        tick(2);
        check("reset held busy", busy, 0);
        mon_skip = 1'b0;

        // release with note 1, octave 3: 227273>>3 = 28409
        expect_level(1'b1, 28409, 1);
        rst = 1'b0;
        wait_tone("post-reset high", 1'b1, 10);
        check("post-reset note_playing", note_playing, 1);
        tick(100);
        en = 1'b0;
        wait_idle("final stop", 30000);
        check("final tone_out", tone_out, 0);

        tick(5);
        check("queue drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/note_tone_gen.md
# note_tone_gen

Downstream stage of the portamento effect: converts the 6-bit note index it produces into an audible square wave on one output pin. Half-period lookup per note, optional octave shift, phase-continuous period changes only at toggle boundaries so glides from the portamento stage never produce runt pulses. Note 0 is a rest; stopping always ends the waveform low.

## Interface
- No parameters; table fixed for a 50 MHz clock.
- clk50mhz  in  1  system clock, 50 MHz, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- note_in  in  6  note index from portamento stage; 0 = rest, 1..63 = semitones, 1 = 110 Hz (A2)
- en  in  1  tone enable; 0 requests stop
- octave  in  2  upward octave shift 0..3, half-period >> octave
- tone_out  out  1  square-wave audio output
- busy  out  1  1 while state = RUN
- note_playing  out  6  note whose period is currently in use, 0 when IDLE

## Operation
- Stage 1: register note_in, en, octave into note_q, en_q, oct_q every cycle.
- Stage 2: registered ROM lookup; half_next = rom(note_q) >> oct_q (18 bits), play_next = en_q && note_q != 0, note_next = note_q.
- ROM: half(n) = round(25e6 / (110 * 2^((n-1)/12))); half(0) = 0 (unused). Anchors: n1 = 227273, n13 = 113636, n25 = 56818, n37 = 28409, n49 = 14205, n63 = 6327.
- Counter cnt, 18 bits; half_cur, 18 bits; both cleared in IDLE.
- States: IDLE, RUN.
- IDLE: tone_out = 0, busy = 0, note_playing = 0. If play_next: half_cur <= half_next, note_playing <= note_next, cnt <= 0, tone_out <= 1, go RUN.
- RUN: cnt increments each cycle. Boundary = (cnt == half_cur - 1). At boundary:
  - play_next = 1: tone_out toggles, cnt <= 0, half_cur <= half_next, note_playing <= note_next.
  - play_next = 0 and tone_out = 1: tone_out <= 0, go IDLE.
  - play_next = 0 and tone_out = 0: stay 0, go IDLE.
- Between boundaries, note/octave/en changes have no effect on tone_out; only the value present in stage 2 on the boundary cycle is sampled.
- Same note re-presented: no restart, waveform continues unbroken.

## Timing
- Reset values: tone_out 0, busy 0, note_playing 0, cnt 0, half_cur 0, pipeline registers 0, state IDLE.
- Reset mid-RUN: outputs forced to reset values on the next edge regardless of phase.
- Start latency: note_in/en applied before edge k -> tone_out and busy rise after edge k+2.
- Each tone_out level lasts exactly half_cur cycles; full period 2*half_cur.
- Period change takes effect at the first boundary at least 2 cycles after the new input; applies to the level that begins at that boundary.
- Stop: ends at the first boundary after play_next falls; worst-case tail = one half-period.
- Minimum half period 6327 >> 3 = 790 cycles; no zero or one-cycle period reachable.
- Simultaneous rst and any input: rst wins.

## Structure
- Shared package: NOTE_W = 6, HALF_W = 18, NOTE_REST = 0, state encoding (IDLE, RUN).
- Sub-module note_period_rom: 64-entry synchronous ROM, note in, 18-bit half-period out, one cycle latency; octave shift applied in parent.
- Parent holds input registers, FSM, counter, output registers.

## Test plan
- Reset, en = 1, note 25, octave 0 -> tone_out rises 3 edges after input, 56818 cycles high, 56818 low, busy = 1, note_playing = 25.
- Note 63, octave 3 -> levels of exactly 790 cycles; octave 1 -> 3163.
- Playing note 25, switch to note 37 mid-high-level -> current high level completes at 56818 cycles, next level 28409 cycles; no intermediate pulse.
- Playing, set note_in = 0 during high level -> high level completes, tone_out 0, busy 0, note_playing 0; repeat during low level -> low level completes, IDLE, no extra pulse.
- Playing, drop en during low level and raise it back before boundary -> waveform unbroken.
- Assert rst 1000 cycles into a high level -> tone_out, busy, note_playing 0 after next edge; release with note 1 -> 227273-cycle levels.
